// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester valid/ready front end sharing one external ALU,
//            round-robin (or fixed priority with ALU_ARB_FIXED_PRIO_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [2*DATA_WIDTH-1:0] req_b,
    input  logic [2*DATA_WIDTH-1:0] req_op,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dout,
    output logic [DATA_WIDTH-1:0]   rsp_flags,
    output logic [DATA_WIDTH-1:0]   alu_a_in,
    output logic [DATA_WIDTH-1:0]   alu_b_in,
    output logic [DATA_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0]   alu_dout,
    input  logic [DATA_WIDTH-1:0]   alu_flags,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_owner;
    logic [1:0]              w_grant_oh;
    logic                    w_grant_idx;
    logic                    w_accept;
    logic                    w_rsp_done;
    logic [DATA_WIDTH-1:0]   w_sel_a;
    logic [DATA_WIDTH-1:0]   w_sel_b;
    logic [DATA_WIDTH-1:0]   w_sel_op;
    logic [DATA_WIDTH-1:0]   r_alu_a;
    logic [DATA_WIDTH-1:0]   r_alu_b;
    logic [DATA_WIDTH-1:0]   r_alu_op;
    logic [DATA_WIDTH-1:0]   r_rsp_dout;
    logic [DATA_WIDTH-1:0]   r_rsp_flags;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                    r_last_grant;
`endif

    always_comb begin
        w_grant_oh = 2'b00;
        case (req_valid)
            2'b01:   w_grant_oh = 2'b01;
            2'b10:   w_grant_oh = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   w_grant_oh = 2'b01;
`else
            // Contention goes to whichever requester was not served last
            2'b11:   w_grant_oh = r_last_grant ? 2'b01 : 2'b10;
`endif
            default: w_grant_oh = 2'b00;
        endcase
    end

    assign w_grant_idx = w_grant_oh[1];
    assign w_accept    = (r_state == S_IDLE) && (|req_valid);
    assign w_rsp_done  = (r_state == S_RESP) && rsp_ready[r_owner];

    assign w_sel_a  = w_grant_idx ? req_a[2*DATA_WIDTH-1:DATA_WIDTH]  : req_a[DATA_WIDTH-1:0];
    assign w_sel_b  = w_grant_idx ? req_b[2*DATA_WIDTH-1:DATA_WIDTH]  : req_b[DATA_WIDTH-1:0];
    assign w_sel_op = w_grant_idx ? req_op[2*DATA_WIDTH-1:DATA_WIDTH] : req_op[DATA_WIDTH-1:0];

    // Ready is forced low while reset is held so no handshake is advertised
    assign req_ready = ((r_state == S_IDLE) && !rst) ? w_grant_oh : 2'b00;
    assign rsp_valid = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (r_state != S_IDLE);

    assign alu_a_in  = r_alu_a;
    assign alu_b_in  = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_dout  = r_rsp_dout;
    assign rsp_flags = r_rsp_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_rsp_done) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_dout  <= '0;
            r_rsp_flags <= '0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_grant_idx;
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_op <= w_sel_op;
            end
            if (r_state == S_EXEC) begin
                r_rsp_dout  <= alu_dout;
                r_rsp_flags <= alu_flags;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant_idx;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed scoreboard bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_a, req_b, req_op;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [DW-1:0]   rsp_dout, rsp_flags;
    logic [DW-1:0]   alu_a_in, alu_b_in, alu_op;
    logic [DW-1:0]   alu_dout, alu_flags;
    logic            busy;

    typedef struct {
        int            idx;
        logic [DW-1:0] dout;
        logic [DW-1:0] flags;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dout(rsp_dout), .rsp_flags(rsp_flags),
        .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_op(alu_op),
        .alu_dout(alu_dout), .alu_flags(alu_flags),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] op, a, b);
        case (op)
            16'd0:   return a + b;
            16'd1:   return a - b;
            16'd2:   return a >> b[3:0];
            16'd3:   return a << b[3:0];
            16'd4:   return a | b;
            16'd5:   return ~(a | b);
            16'd6:   return a & b;
            16'd7:   return ~(a & b);
            16'd8:   return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Flags: bit0 zero, bit1 negative, bit2 carry/borrow for ADD/SUB
    function automatic logic [DW-1:0] ref_flags(input logic [DW-1:0] op, a, b, r);
        logic [DW:0] s;
        logic        c;
        s = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        if (op == 16'd0) c = s[DW];
        if (op == 16'd1) c = (a < b);
        return {13'd0, c, r[DW-1], (r == '0)};
    endfunction

    always_comb begin
        alu_dout  = ref_result(alu_op, alu_a_in, alu_b_in);
        alu_flags = ref_flags(alu_op, alu_a_in, alu_b_in, alu_dout);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [DW-1:0] a, b, op, dout);
        exp_t e;
        e.idx   = idx;
        e.dout  = dout;
        e.flags = ref_flags(op, a, b, dout);
        sb.push_back(e);
    endtask

    task automatic set_payload(input int idx, input logic [DW-1:0] a, b, op);
        req_a[idx*DW +: DW]  = a;
        req_b[idx*DW +: DW]  = b;
        req_op[idx*DW +: DW] = op;
    endtask

    // Raise a request, wait for its accept, cross the handshake edge
    task automatic send(input int idx, input logic [DW-1:0] a, b, op, dout, input bit chk_lat);
        set_payload(idx, a, b, op);
        req_valid[idx] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready[idx]) break;
            tick();
        end
        check("accept", {31'd0, req_ready[idx]}, 32'd1);
        push_exp(idx, a, b, op, dout);
        tick();
        req_valid[idx] = 1'b0;
        if (chk_lat) begin
            check("lat_exec_valid", {30'd0, rsp_valid}, 32'd0);
            check("lat_exec_busy", {31'd0, busy}, 32'd1);
            tick();
            check("lat_resp_valid", {30'd0, rsp_valid}, 32'd1 << idx);
        end
    endtask

    task automatic collect(input string tag);
        exp_t e;
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid != 2'b00) break;
            tick();
        end
        check({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, {30'd0, rsp_valid}, 32'd1 << e.idx);
            check({tag, "_dout"}, {16'd0, rsp_dout}, {16'd0, e.dout});
            check({tag, "_flags"}, {16'd0, rsp_flags}, {16'd0, e.flags});
            rsp_ready = 2'b00;
            rsp_ready[e.idx] = 1'b1;
        end
        tick();
        rsp_ready = 2'b00;
        check({tag, "_done"}, {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_idx;
        logic [DW-1:0] held;

        rst = 1'b1; req_valid = 2'b01; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0;
        tick(); tick();
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_op", {16'd0, alu_op}, 32'd0);
        check("rst_rsp_dout", {16'd0, rsp_dout}, 32'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // Single requester traffic
        send(0, 16'h0355, 16'h0005, 16'd0, 16'h035A, 1'b1); collect("add_r0");
        send(1, 16'h0355, 16'h0005, 16'd3, 16'h6AA0, 1'b1); collect("sll_r1");
        send(1, 16'h0355, 16'h0005, 16'd2, 16'h001A, 1'b1); collect("srl_r1");
        send(1, 16'h0355, 16'h0005, 16'd8, 16'h0350, 1'b1); collect("xor_r1");

        // Continuous contention
        set_payload(0, 16'h0355, 16'h0005, 16'd1);
        set_payload(1, 16'h0355, 16'h0005, 16'd4);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 20; n++) begin
                #1;
                if (req_ready != 2'b00) break;
                tick();
            end
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = k % 2;
`endif
            check("rr_grant", {30'd0, req_ready}, 32'd1 << exp_idx);
            if (exp_idx == 0) push_exp(0, 16'h0355, 16'h0005, 16'd1, 16'h0350);
            else              push_exp(1, 16'h0355, 16'h0005, 16'd4, 16'h0355);
            tick();
            collect("rr_rsp");
        end
        req_valid = 2'b00;
        tick();

        // Response back-pressure; non-owner rsp_ready must be ignored
        send(0, 16'h0355, 16'h0005, 16'd6, 16'h0005, 1'b1);
        set_payload(1, 16'h0355, 16'h0005, 16'd7);
        req_valid[1] = 1'b1;
        rsp_ready = 2'b10;
        held = rsp_dout;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("stall_valid", {30'd0, rsp_valid}, 32'd1);
            check("stall_dout", {16'd0, rsp_dout}, {16'd0, held});
            check("stall_busy", {31'd0, busy}, 32'd1);
            check("stall_req_ready", {30'd0, req_ready}, 32'd0);
            tick();
        end
        collect("stall_rsp");
        #1;
        check("post_hs_ready", {30'd0, req_ready}, 32'd2);
        check("post_hs_busy", {31'd0, busy}, 32'd0);
        push_exp(1, 16'h0355, 16'h0005, 16'd7, 16'hFFFA);
        tick();
        req_valid = 2'b00;
        collect("nand_r1");

        // Reset during EXEC drops the transaction
        send(1, 16'h0355, 16'h0005, 16'd5, 16'hFCAA, 1'b0);
        void'(sb.pop_front());
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_alu_a", {16'd0, alu_a_in}, 32'd0);
        check("arst_alu_b", {16'd0, alu_b_in}, 32'd0);
        check("arst_alu_op", {16'd0, alu_op}, 32'd0);
        check("arst_rsp_dout", {16'd0, rsp_dout}, 32'd0);
        check("arst_rsp_flags", {16'd0, rsp_flags}, 32'd0);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("arst_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        // First contention after reset favours requester 0; withdrawn before the edge
        req_valid = 2'b11;
        #1;
        check("arst_first_grant", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        tick();
        send(1, 16'h0355, 16'h0005, 16'd5, 16'hFCAA, 1'b1);
        collect("nor_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
